// File: rtl/oob_link_pkg.sv
// Shared encodings for the OOB link manager: FSM states, backoff cap, speed indices.
// Pure constants and a helper; no logic, no latency.
package oob_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_UP      = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_SPEED   = 3'd5,
    ST_FAILED  = 3'd6
  } state_t;

  localparam int unsigned BACKOFF_SHIFT_CAP = 3;
  localparam int unsigned GEN1 = 0;

  // Attempt n waits base << (n-1), doubling up to the cap.
  function automatic int unsigned backoff_shift(input int unsigned attempt);
    if (attempt == 0) return 0;
    return (attempt - 1 > BACKOFF_SHIFT_CAP) ? BACKOFF_SHIFT_CAP : attempt - 1;
  endfunction

endpackage

// File: rtl/oob_link_mgr_sat_counter.sv
// Width-parametrised saturating event counter, clear wins over increment.
// Latency: count updates one cycle after inc_i/clr_i; no backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/oob_link_mgr.sv
// Link manager in front of the oob sequencer: starts OOB, retries with exponential backoff, falls back in speed.
// Latency: oob_start one cycle after IDLE conditions hold; waits on oob_busy and speed_change_ack handshakes.
module oob_link_mgr
  import oob_link_pkg::*;
#(
  parameter int MAX_RETRIES     = 4,
  parameter int BACKOFF_CYCLES  = 1024,
  parameter int CLK_SPEED_GRADE = 1,
  parameter int SPEED_NUM       = 3,
  parameter int CNT_WIDTH       = 8,
  localparam int SW = (SPEED_NUM > 1) ? $clog2(SPEED_NUM) : 1,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 gtx_ready,
  input  logic                 rxbyteisaligned,
  input  logic                 oob_busy,
  input  logic                 link_up,
  input  logic                 link_down,
  input  logic                 oob_error,
  input  logic                 oob_silence,
  input  logic                 cominit_req,
  output logic                 oob_start,
  output logic                 cominit_allow,
  output logic [SW-1:0]        speed_sel,
  output logic                 speed_change_req,
  input  logic                 speed_change_ack,
  output logic                 link_state,
  output logic                 phy_ready,
  output logic                 fail,
  output logic [RW-1:0]        retry_cnt,
  output logic [CNT_WIDTH-1:0] linkdown_cnt,
  output logic [CNT_WIDTH-1:0] error_cnt,
  input  logic                 clr_cnt
);

  localparam int TW = $clog2(32 * BACKOFF_CYCLES + 1);
  localparam logic [SW-1:0] SPEED_TOP    = SW'(SPEED_NUM - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [TW-1:0] BACKOFF_BASE = TW'(BACKOFF_CYCLES * CLK_SPEED_GRADE);

  state_t        state_q;
  logic          oob_start_q;
  logic          cominit_allow_q;
  logic          speed_req_q;
  logic          link_state_q;
  logic          fail_q;
  logic [SW-1:0] speed_sel_q;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_inc, ld_inc;

  always_comb begin
    retry_d = retry_q + RW'(1);
    timer_d = BACKOFF_BASE << backoff_shift(32'(retry_d));
  end

  assign err_inc = enable & gtx_ready & (state_q == ST_WAIT) & ~link_up & oob_error;
  assign ld_inc  = enable & gtx_ready & (state_q == ST_UP) & link_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      oob_start_q     <= 1'b0;
      cominit_allow_q <= 1'b0;
      speed_req_q     <= 1'b0;
      link_state_q    <= 1'b0;
      fail_q          <= 1'b0;
      speed_sel_q     <= SPEED_TOP;
      retry_q         <= '0;
      timer_q         <= '0;
    end else begin
      oob_start_q     <= 1'b0;
      cominit_allow_q <= 1'b0;
      if (!enable) begin
        state_q      <= ST_IDLE;
        fail_q       <= 1'b0;
        retry_q      <= '0;
        speed_sel_q  <= SPEED_TOP;
        speed_req_q  <= 1'b0;
        link_state_q <= 1'b0;
      // A rate change in flight and a declared failure both outlive gtx resets.
      end else if (!gtx_ready && (state_q != ST_IDLE) && (state_q != ST_SPEED) &&
                   (state_q != ST_FAILED)) begin
        state_q      <= ST_IDLE;
        link_state_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (gtx_ready && !oob_busy) begin
              state_q     <= ST_START;
              oob_start_q <= 1'b1;
            end
          end
          ST_START: state_q <= ST_WAIT;
          ST_WAIT: begin
            if (link_up) begin
              state_q      <= ST_UP;
              link_state_q <= 1'b1;
              retry_q      <= '0;
            end else if (oob_error || oob_silence) begin
              retry_q <= retry_d;
              if (retry_d == RETRY_MAX) begin
                state_q <= ST_SPEED;
                if (speed_sel_q != SW'(GEN1)) begin
                  speed_sel_q <= speed_sel_q - SW'(1);
                  speed_req_q <= 1'b1;
                end
              end else begin
                state_q <= ST_BACKOFF;
                timer_q <= timer_d;
              end
            end
          end
          ST_BACKOFF: begin
            if (timer_q == '0) state_q <= ST_IDLE;
            else               timer_q <= timer_q - TW'(1);
          end
          ST_SPEED: begin
            // No request raised on entry means the lowest rate was already in use.
            if (!speed_req_q) begin
              state_q <= ST_FAILED;
              fail_q  <= 1'b1;
            end else if (speed_change_ack) begin
              speed_req_q <= 1'b0;
              retry_q     <= '0;
              state_q     <= ST_IDLE;
            end
          end
          ST_UP: begin
            if (link_down) begin
              link_state_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (cominit_req) begin
              cominit_allow_q <= 1'b1;
              link_state_q    <= 1'b0;
              state_q         <= ST_WAIT;
            end
          end
          ST_FAILED: state_q <= ST_FAILED;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (err_inc),
    .cnt_o (error_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_linkdown_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_cnt),
    .inc_i (ld_inc),
    .cnt_o (linkdown_cnt)
  );

  assign oob_start        = oob_start_q;
  assign cominit_allow    = cominit_allow_q;
  assign speed_sel        = speed_sel_q;
  assign speed_change_req = speed_req_q;
  assign link_state       = link_state_q;
  assign phy_ready        = link_state_q & gtx_ready & rxbyteisaligned;
  assign fail             = fail_q;
  assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_oob_link_mgr.sv
// Bench for oob_link_mgr: randomized OOB outcomes checked against a rule-level model.
module tb_oob_link_mgr;

  localparam int MAX_RETRIES    = 4;
  localparam int BACKOFF_CYCLES = 16;
  localparam int GRADE          = 2;
  localparam int SPEED_NUM      = 3;
  localparam int CNT_WIDTH      = 8;
  localparam int CNT_MAX        = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, gtx_ready = 1'b0, rxbyteisaligned = 1'b0, oob_busy = 1'b0;
  logic link_up = 1'b0, link_down = 1'b0, oob_error = 1'b0, oob_silence = 1'b0;
  logic cominit_req = 1'b0, speed_change_ack = 1'b0, clr_cnt = 1'b0;
  logic oob_start, cominit_allow, speed_change_req, link_state, phy_ready, fail;
  logic [1:0] speed_sel;
  logic [2:0] retry_cnt;
  logic [CNT_WIDTH-1:0] linkdown_cnt, error_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_pulses = 0;
  int allow_pulses = 0;
  int m_speed, m_retry, m_error, m_linkdown;

  oob_link_mgr #(
    .MAX_RETRIES(MAX_RETRIES), .BACKOFF_CYCLES(BACKOFF_CYCLES), .CLK_SPEED_GRADE(GRADE),
    .SPEED_NUM(SPEED_NUM), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .gtx_ready(gtx_ready),
    .rxbyteisaligned(rxbyteisaligned), .oob_busy(oob_busy), .link_up(link_up),
    .link_down(link_down), .oob_error(oob_error), .oob_silence(oob_silence),
    .cominit_req(cominit_req), .oob_start(oob_start), .cominit_allow(cominit_allow),
    .speed_sel(speed_sel), .speed_change_req(speed_change_req),
    .speed_change_ack(speed_change_ack), .link_state(link_state), .phy_ready(phy_ready),
    .fail(fail), .retry_cnt(retry_cnt), .linkdown_cnt(linkdown_cnt),
    .error_cnt(error_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oob_start === 1'b1) start_pulses++;
    if (cominit_allow === 1'b1) allow_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int backoff_len(input int attempt);
    int sh;
    sh = attempt - 1;
    if (sh > 3) sh = 3;
    return BACKOFF_CYCLES * GRADE * (1 << sh);
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (oob_start === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  // From START: enter WAIT, fail on the k-th WAIT cycle by error or silence.
  task automatic inject_failure(input int k, input bit use_err);
    step();
    for (int i = 1; i < k; i++) step();
    oob_error   = use_err;
    oob_silence = !use_err || ($urandom_range(0, 1) == 1);
    step();
    oob_error   = 1'b0;
    oob_silence = 1'b0;
    if (use_err) m_error++;
    m_retry++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gtx_ready = 1'b1;
    repeat (3) step();
    m_speed = SPEED_NUM - 1; m_retry = 0; m_error = 0; m_linkdown = 0;
    n_checks++;
    if ({oob_start, cominit_allow, speed_change_req, link_state, phy_ready, fail} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {oob_start, cominit_allow, speed_change_req, link_state, phy_ready, fail});
    end
    n_checks++;
    if (speed_sel !== 2'(m_speed)) begin
      n_errors++; $display("FAIL reset_speed_sel: got %0d want %0d", speed_sel, m_speed);
    end
    n_checks++;
    if ({retry_cnt, error_cnt, linkdown_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_counters: got retry %0d err %0d ld %0d want 0", retry_cnt, error_cnt, linkdown_cnt);
    end
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (start_pulses !== 0) begin
      n_errors++; $display("FAIL reset_disabled_start: got %0d starts want 0", start_pulses);
    end
  endtask

  task automatic test_happy_path();
    int w, st0;
    st0 = start_pulses;
    enable = 1'b1;
    wait_start(4, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL happy_start_latency: got %0d want 1", w); end
    step();
    n_checks++;
    if (oob_start !== 1'b0) begin n_errors++; $display("FAIL happy_start_width: got %b want 0", oob_start); end
    repeat (4) step();
    link_up = 1'b1; step(); link_up = 1'b0;
    m_retry = 0;
    n_checks++;
    if ({link_state, phy_ready} !== 2'b10) begin
      n_errors++; $display("FAIL happy_link: got link %b phy %b want 1 0", link_state, phy_ready);
    end
    n_checks++;
    if (retry_cnt !== 3'(m_retry)) begin
      n_errors++; $display("FAIL happy_retry: got %0d want %0d", retry_cnt, m_retry);
    end
    rxbyteisaligned = 1'b1;
    #1;
    n_checks++;
    if (phy_ready !== 1'b1) begin n_errors++; $display("FAIL happy_phy_ready: got %b want 1", phy_ready); end
    n_checks++;
    if (start_pulses !== st0 + 1) begin
      n_errors++; $display("FAIL happy_start_count: got %0d want %0d", start_pulses - st0, 1);
    end
  endtask

  task automatic test_link_events();
    int w, d, st0, al0;
    link_down = 1'b1; step(); link_down = 1'b0;
    m_linkdown++;
    n_checks++;
    if ({link_state, phy_ready} !== 2'b00 || linkdown_cnt !== CNT_WIDTH'(sat(m_linkdown))) begin
      n_errors++;
      $display("FAIL linkdown: got link %b phy %b cnt %0d want 0 0 %0d", link_state, phy_ready, linkdown_cnt, m_linkdown);
    end
    wait_start(4, w);
    n_checks++;
    if (w !== 1 || speed_sel !== 2'(m_speed)) begin
      n_errors++; $display("FAIL linkdown_restart: got wait %0d speed %0d want 1 %0d", w, speed_sel, m_speed);
    end
    d = $urandom_range(1, 6);
    step();
    repeat (d - 1) step();
    link_up = 1'b1; step(); link_up = 1'b0;
    st0 = start_pulses; al0 = allow_pulses;
    cominit_req = 1'b1; step(); cominit_req = 1'b0;
    n_checks++;
    if ({cominit_allow, link_state} !== 2'b10) begin
      n_errors++; $display("FAIL cominit_grant: got allow %b link %b want 1 0", cominit_allow, link_state);
    end
    step();
    n_checks++;
    if (cominit_allow !== 1'b0) begin n_errors++; $display("FAIL cominit_width: got %b want 0", cominit_allow); end
    cominit_req = 1'b1; step(); cominit_req = 1'b0;
    repeat (5) step();
    n_checks++;
    if (allow_pulses !== al0 + 1 || start_pulses !== st0) begin
      n_errors++;
      $display("FAIL cominit_wait: got allows %0d starts %0d want 1 0", allow_pulses - al0, start_pulses - st0);
    end
    link_up = 1'b1; step(); link_up = 1'b0;
    link_down = 1'b1; cominit_req = 1'b1; step(); link_down = 1'b0; cominit_req = 1'b0;
    m_linkdown++;
    n_checks++;
    if (cominit_allow !== 1'b0 || link_state !== 1'b0 || linkdown_cnt !== CNT_WIDTH'(sat(m_linkdown))) begin
      n_errors++;
      $display("FAIL down_vs_cominit: got allow %b link %b cnt %0d want 0 0 %0d",
               cominit_allow, link_state, linkdown_cnt, m_linkdown);
    end
    wait_start(4, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL down_vs_cominit_restart: got %0d want 1", w); end
  endtask

  task automatic test_retry_exhaust();
    int w, k, h, L, prev_start, st0;
    bit e;
    enable = 1'b0; step(); enable = 1'b1;
    m_retry = 0; m_speed = SPEED_NUM - 1;
    n_checks++;
    if (retry_cnt !== 3'(m_retry) || speed_sel !== 2'(m_speed) || fail !== 1'b0) begin
      n_errors++; $display("FAIL disable_state: got retry %0d speed %0d fail %b", retry_cnt, speed_sel, fail);
    end
    wait_start(3, w);
    prev_start = cyc;
    for (int sp = SPEED_NUM - 1; sp >= 0; sp--) begin
      for (int a = 1; a <= MAX_RETRIES; a++) begin
        k = $urandom_range(1, 3);
        e = ($urandom_range(0, 1) == 1);
        inject_failure(k, e);
        n_checks++;
        if (retry_cnt !== 3'(m_retry) || error_cnt !== CNT_WIDTH'(sat(m_error))) begin
          n_errors++;
          $display("FAIL retry_count sp%0d a%0d: got retry %0d err %0d want %0d %0d",
                   sp, a, retry_cnt, error_cnt, m_retry, sat(m_error));
        end
        if (a < MAX_RETRIES) begin
          L = backoff_len(m_retry);
          wait_start(L + 20, w);
          n_checks++;
          if (w < 0 || cyc - prev_start !== L + k + 3) begin
            n_errors++;
            $display("FAIL backoff_gap sp%0d a%0d: got %0d want %0d", sp, a, cyc - prev_start, L + k + 3);
          end
          prev_start = cyc;
        end
      end
      if (sp > 0) begin
        m_speed--;
        n_checks++;
        if (speed_change_req !== 1'b1 || speed_sel !== 2'(m_speed)) begin
          n_errors++; $display("FAIL speed_req: got req %b speed %0d want 1 %0d", speed_change_req, speed_sel, m_speed);
        end
        h = $urandom_range(1, 4);
        gtx_ready = 1'b0;
        repeat (h) step();
        gtx_ready = 1'b1;
        n_checks++;
        if (speed_change_req !== 1'b1) begin n_errors++; $display("FAIL speed_req_hold: got %b want 1", speed_change_req); end
        speed_change_ack = 1'b1; step(); speed_change_ack = 1'b0;
        m_retry = 0;
        n_checks++;
        if (speed_change_req !== 1'b0 || retry_cnt !== 3'(m_retry)) begin
          n_errors++; $display("FAIL speed_ack: got req %b retry %0d want 0 0", speed_change_req, retry_cnt);
        end
        wait_start(3, w);
        n_checks++;
        if (w !== 1) begin n_errors++; $display("FAIL speed_restart: got %0d want 1", w); end
        prev_start = cyc;
      end else begin
        step();
        n_checks++;
        if (fail !== 1'b1 || speed_change_req !== 1'b0 || speed_sel !== 2'(m_speed)) begin
          n_errors++; $display("FAIL exhausted: got fail %b req %b speed %0d want 1 0 0", fail, speed_change_req, speed_sel);
        end
      end
    end
    st0 = start_pulses;
    repeat (40) step();
    n_checks++;
    if (start_pulses !== st0 || fail !== 1'b1) begin
      n_errors++; $display("FAIL failed_hold: got starts %0d fail %b want 0 1", start_pulses - st0, fail);
    end
    enable = 1'b0; step();
    m_speed = SPEED_NUM - 1; m_retry = 0;
    n_checks++;
    if (fail !== 1'b0 || speed_sel !== 2'(m_speed) || retry_cnt !== 3'(m_retry)) begin
      n_errors++; $display("FAIL fail_clear: got fail %b speed %0d retry %0d want 0 %0d 0", fail, speed_sel, retry_cnt, m_speed);
    end
    enable = 1'b1;
    wait_start(3, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL fail_restart: got %0d want 1", w); end
  endtask

  task automatic test_counters();
    int w, choice, iter;
    iter = 0;
    while (m_error < 300 && iter < 1000) begin
      iter++;
      choice = $urandom_range(0, 3);
      step();
      oob_error   = (choice <= 2);
      oob_silence = (choice == 1) || (choice == 3);
      link_up     = (choice == 2);
      step();
      oob_error = 1'b0; oob_silence = 1'b0; link_up = 1'b0;
      if (choice <= 1) m_error++;
      n_checks++;
      if (error_cnt !== CNT_WIDTH'(sat(m_error))) begin
        n_errors++; $display("FAIL error_cnt iter %0d: got %0d want %0d", iter, error_cnt, sat(m_error));
      end
      enable = 1'b0; step(); enable = 1'b1;
      wait_start(3, w);
      if (w < 0) begin
        n_checks++; n_errors++;
        $display("FAIL counter_loop_start: got no start within 3 cycles want 1");
        break;
      end
    end
    n_checks++;
    if (error_cnt !== 8'd255) begin n_errors++; $display("FAIL error_cnt_saturate: got %0d want 255", error_cnt); end
    step();
    oob_error = 1'b1; clr_cnt = 1'b1; step(); oob_error = 1'b0; clr_cnt = 1'b0;
    m_error = 0; m_linkdown = 0;
    n_checks++;
    if (error_cnt !== CNT_WIDTH'(m_error) || linkdown_cnt !== CNT_WIDTH'(m_linkdown)) begin
      n_errors++; $display("FAIL clr_priority: got err %0d ld %0d want 0 0", error_cnt, linkdown_cnt);
    end
    enable = 1'b0; step(); enable = 1'b1;
    wait_start(3, w);
    step();
    oob_error = 1'b1; step(); oob_error = 1'b0;
    m_error++;
    n_checks++;
    if (error_cnt !== CNT_WIDTH'(m_error)) begin
      n_errors++; $display("FAIL error_after_clr: got %0d want %0d", error_cnt, m_error);
    end
  endtask

  task automatic test_async_reset();
    int w, st0;
    enable = 1'b0; step(); enable = 1'b1;
    m_retry = 0;
    wait_start(3, w);
    inject_failure(1, 1'b0);
    repeat (5) step();
    gtx_ready = 1'b0; step(); gtx_ready = 1'b1;
    n_checks++;
    if (retry_cnt !== 3'(m_retry) || link_state !== 1'b0) begin
      n_errors++; $display("FAIL gtx_loss_retry_kept: got %0d want %0d", retry_cnt, m_retry);
    end
    wait_start(3, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL gtx_loss_restart: got %0d want 1", w); end
    inject_failure(1, 1'b0);
    repeat (10) step();
    #3 rst = 1'b1;
    #1;
    m_speed = SPEED_NUM - 1; m_retry = 0; m_error = 0; m_linkdown = 0;
    n_checks++;
    if ({oob_start, cominit_allow, speed_change_req, link_state, fail} !== 5'b0 ||
        speed_sel !== 2'(m_speed) || retry_cnt !== 3'(m_retry) || error_cnt !== CNT_WIDTH'(m_error)) begin
      n_errors++;
      $display("FAIL rst_mid_backoff: got speed %0d retry %0d err %0d req %b", speed_sel, retry_cnt, error_cnt, speed_change_req);
    end
    st0 = start_pulses;
    repeat (4) step();
    n_checks++;
    if (start_pulses !== st0) begin n_errors++; $display("FAIL rst_no_start: got %0d starts want 0", start_pulses - st0); end
    rst = 1'b0;
    wait_start(3, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL rst_release_start: got %0d want 1", w); end
    for (int a = 1; a <= MAX_RETRIES; a++) begin
      inject_failure(1, 1'b0);
      if (a < MAX_RETRIES) wait_start(backoff_len(m_retry) + 20, w);
    end
    n_checks++;
    if (speed_change_req !== 1'b1 || speed_sel !== 2'(m_speed - 1)) begin
      n_errors++; $display("FAIL pre_rst_speed: got req %b speed %0d want 1 %0d", speed_change_req, speed_sel, m_speed - 1);
    end
    step();
    #2 rst = 1'b1;
    #1;
    m_retry = 0;
    n_checks++;
    if (speed_change_req !== 1'b0 || speed_sel !== 2'(m_speed) || retry_cnt !== 3'(m_retry) || oob_start !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_speed: got req %b speed %0d retry %0d want 0 %0d 0", speed_change_req, speed_sel, retry_cnt, m_speed);
    end
    oob_busy = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    st0 = start_pulses;
    repeat (3) step();
    n_checks++;
    if (start_pulses !== st0 || oob_start !== 1'b0) begin
      n_errors++; $display("FAIL busy_blocks_start: got %0d starts want 0", start_pulses - st0);
    end
    oob_busy = 1'b0;
    wait_start(3, w);
    n_checks++;
    if (w !== 1) begin n_errors++; $display("FAIL busy_release_start: got %0d want 1", w); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_link_events();
    test_retry_exhaust();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oob_link_mgr.md
Name: oob_link_mgr

Overview:
Parametrised link-management controller, the successor to the SATA OOB control wrapper; it sits between the gtx reset logic and the `oob` sequencer core.
- Drives `oob_start`/`cominit_allow` into `oob`.
- Retries failed OOB with exponential backoff.
- Falls back through SPEED_NUM line-rate generations, declaring failure only after the lowest rate is exhausted.
- Tracks link-down/error statistics and produces `phy_ready`.

Parameters:
MAX_RETRIES, 4, failed OOB attempts at one speed before fallback (>=1)
BACKOFF_CYCLES, 1024, base backoff length at 75 MHz
CLK_SPEED_GRADE, 1, 1/2/4 = 75/150/300 MHz; scales backoff
SPEED_NUM, 3, number of supported generations (>=1)
CNT_WIDTH, 8, statistics counter width

Ports:
clk  in  1  sata clock (usrclk2)
rst  in  1  asynchronous reset, active-high
enable  in  1  0 forces IDLE and clears fail
gtx_ready  in  1  all gtx resets done
rxbyteisaligned  in  1  rx comma alignment
oob_busy  in  1  from oob: cannot accept start
link_up  in  1  from oob: pulse, link established
link_down  in  1  from oob: pulse, link lost
oob_error  in  1  from oob: unexpected timeout
oob_silence  in  1  from oob: no COMINIT response
cominit_req  in  1  from oob: device-initiated COMINIT
oob_start  out  1  one-cycle start pulse to oob
cominit_allow  out  1  one-cycle grant of cominit_req
speed_sel  out  $clog2(SPEED_NUM) (min 1)  selected generation, SPEED_NUM-1 = fastest
speed_change_req  out  1  level, held until ack
speed_change_ack  in  1  gtx rate change complete
link_state  out  1  link up
phy_ready  out  1  link_state & gtx_ready & rxbyteisaligned (combinational)
fail  out  1  all speeds exhausted
retry_cnt  out  $clog2(MAX_RETRIES+1)  attempts at current speed
linkdown_cnt  out  CNT_WIDTH  saturating link-down count
error_cnt  out  CNT_WIDTH  saturating oob_error count
clr_cnt  in  1  clears linkdown_cnt/error_cnt

Behaviour:
- Reset (async):
  - state IDLE.
  - All outputs 0 except speed_sel = SPEED_NUM-1.
- States: IDLE, START, WAIT, UP, BACKOFF, SPEED, FAILED.
- Global priority each cycle: rst > ~enable > ~gtx_ready > state logic.
  - ~enable: go IDLE, clear fail/retry_cnt, speed_sel = SPEED_NUM-1, drop speed_change_req.
  - ~gtx_ready in any non-IDLE state other than SPEED: go IDLE, link_state 0, retry_cnt kept.
- IDLE: enable & gtx_ready & ~oob_busy -> START.
- START: oob_start=1 for exactly this cycle -> WAIT.
- WAIT:
  - link_up -> UP; link_state 1 next cycle; retry_cnt 0.
  - Else oob_error (error_cnt++) or oob_silence -> retry_cnt++.
  - After the increment: if retry_cnt == MAX_RETRIES -> SPEED, else -> BACKOFF.
  - Priority: link_up > oob_error > oob_silence.
  - Any cominit_req in WAIT is ignored.
- BACKOFF:
  - Timer loaded on entry with (BACKOFF_CYCLES*CLK_SPEED_GRADE) << min(retry_cnt-1,3).
  - Decrements each cycle; -> IDLE the cycle after it reads 0.
  - Timer width covers 8*BACKOFF_CYCLES*4.
- SPEED:
  - If speed_sel == 0: -> FAILED.
  - Else on entry speed_sel-- and speed_change_req=1; hold until speed_change_ack.
  - On ack: drop req, retry_cnt 0, -> IDLE. gtx_ready loss is ignored while in SPEED.
- UP:
  - link_down: link_state 0, linkdown_cnt++, -> IDLE; speed_sel kept.
  - Else cominit_req: cominit_allow=1 one cycle, link_state 0, -> WAIT.
  - link_down wins over cominit_req in the same cycle.
- FAILED: fail=1; exits only via ~enable.
- Counters:
  - linkdown_cnt/error_cnt saturate at all-ones.
  - clr_cnt wins over a same-cycle increment.
  - retry_cnt never exceeds MAX_RETRIES.
- Pulses in non-listed states are ignored.
- rst mid-sequence aborts immediately; oob_start never emitted during rst.

Decomposition:
- Package oob_link_pkg:
  - state encoding constants.
  - backoff shift cap (3).
  - speed index constants (GEN1=0).
- One natural sub-module: sat_counter (width-parametrised saturating counter with clear/inc, clear priority), instantiated twice.

Test Plan:
- Happy path: gtx_ready=1, enable=1, link_up 5 cycles after oob_start -> oob_start exactly 1 pulse, link_state=1, phy_ready=1 once rxbyteisaligned=1, retry_cnt=0.
- Retry/backoff: BACKOFF_CYCLES=16, GRADE=2, oob_silence every attempt, MAX_RETRIES=4, SPEED_NUM=3.
  - Starts spaced 32/64/128 cycles (+3 overhead).
  - 4th silence -> speed_change_req=1, speed_sel=1; ack -> retry_cnt=0, new oob_start.
- Exhaustion: continued silence until speed_sel=0 and 4 more failures -> fail=1.
  - enable=0 -> fail=0, speed_sel=2.
  - enable=1 -> new start.
- Link loss and device COMINIT:
  - In UP, link_down pulse -> linkdown_cnt=1, link_state=0, restart at same speed.
  - In UP, cominit_req -> cominit_allow 1-cycle pulse, state WAIT, no oob_start.
  - link_down and cominit_req in the same cycle -> only link_down handled.
- Counters: force 300 oob_error events (CNT_WIDTH=8) -> error_cnt=255 saturates; clr_cnt coincident with an oob_error -> error_cnt=0.
- Async reset: assert rst mid-BACKOFF and mid-SPEED (req high), both asynchronously between clock edges.
  - All outputs drop immediately; speed_sel=2; no oob_start until rst released and the IDLE conditions hold.
